instruction_fetch: RTL

//   Fetch stage between the PC and the decode/execute stage. Owns the program counter,

---
 rtl/instruction_fetch_pkg.sv | 18 +
 rtl/fetch_pc_reg.sv | 35 +++
 rtl/instruction_fetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: HALT word, FSM encoding, opcode field position.
package instruction_fetch_pkg;

  localparam logic [15:0] HALT_INST = 16'h0000;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load beats increment; increment wraps modulo 2**ADDR_W.
module fetch_pc_reg #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_vld,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_vld) begin
      pc_d = redirect_addr;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC -> comb ROM -> IR, one word/cycle, freezes on !inst_ready, flushes on redirect.
// Optional HALT_ON_END_EN: a fetch from the last ROM address halts instead of wrapping.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int INST_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc;
  logic              transfer, load, end_hit, halt_hit, pc_inc;

  fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
    .clk           (clk),
    .rst           (rst),
    .redirect_vld  (redirect_valid),
    .redirect_addr (redirect_addr),
    .inc           (pc_inc),
    .pc            (pc)
  );

  always_comb begin
    transfer = valid_q & inst_ready;
    load     = (state_q != ST_HALT) & (~valid_q | inst_ready) & ~redirect_valid;
`ifdef HALT_ON_END_EN
    end_hit  = &pc;
`else
    end_hit  = 1'b0;
`endif
    halt_hit = load & ((rom_inst == INST_W'(HALT_INST)) | end_hit);
    // An end-of-ROM halt keeps the PC on the last address rather than wrapping.
    pc_inc   = load & ~end_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN, ST_STALL: begin
          if (halt_hit)                   state_d = ST_HALT;
          else if (valid_q & ~inst_ready) state_d = ST_STALL;
          else                            state_d = ST_RUN;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (redirect_valid) begin
      valid_d = 1'b0;
    end else if (load) begin
      inst_d   = rom_inst;
      pc_out_d = pc;
      valid_d  = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
    cnt_d = cnt_q;
    if (transfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    rom_addr    = pc;
    inst_out    = inst_q;
    pc_out      = pc_out_q;
    inst_valid  = valid_q;
    fetch_count = cnt_q;
    halted      = (state_q == ST_HALT);
  end

endmodule
